// File: rtl/psram_request_arbiter_if.sv
// psram_request_arbiter_if: requester and controller signals of the PSRAM command-port arbiter
interface psram_request_arbiter_if #(
  parameter int ADDRESS_BITWIDTH = 32,
  parameter int DATA_BITWIDTH    = 64
);
  logic                        r0_req;
  logic [ADDRESS_BITWIDTH-1:0] r0_addr;
  logic                        r0_write;
  logic [DATA_BITWIDTH-1:0]    r0_wdata;
  logic                        r0_ack;
  logic [DATA_BITWIDTH-1:0]    r0_rdata;
  logic                        r1_req;
  logic [ADDRESS_BITWIDTH-1:0] r1_addr;
  logic                        r1_write;
  logic [DATA_BITWIDTH-1:0]    r1_wdata;
  logic                        r1_ack;
  logic [DATA_BITWIDTH-1:0]    r1_rdata;
  logic                        m_valid;
  logic                        m_ready;
  logic [ADDRESS_BITWIDTH-1:0] m_addr;
  logic                        m_write;
  logic [DATA_BITWIDTH-1:0]    m_wdata;
  logic                        m_done;
  logic [DATA_BITWIDTH-1:0]    m_rdata;
  logic                        grant;
  logic                        busy;
  logic                        timeout_err;
  modport slave (
    input  r0_req, r0_addr, r0_write, r0_wdata, r1_req, r1_addr, r1_write, r1_wdata,
    input  m_ready, m_done, m_rdata,
    output r0_ack, r0_rdata, r1_ack, r1_rdata, m_valid, m_addr, m_write, m_wdata,
    output grant, busy, timeout_err
  );
  modport master (
    output r0_req, r0_addr, r0_write, r0_wdata, r1_req, r1_addr, r1_write, r1_wdata,
    output m_ready, m_done, m_rdata,
    input  r0_ack, r0_rdata, r1_ack, r1_rdata, m_valid, m_addr, m_write, m_wdata,
    input  grant, busy, timeout_err
  );
endinterface

// File: rtl/psram_request_arbiter.sv
// psram_request_arbiter: round-robin owner of the PSRAM command port with completion return and watchdog
module psram_request_arbiter #(
  parameter int ADDRESS_BITWIDTH = 32,
  parameter int DATA_BITWIDTH    = 64,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input logic clk,
  input logic rst,
  psram_request_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, next;
  logic last, to_flag, pick, any_req, start, expire, done_ok;
  logic [WW-1:0] wd;
  assign any_req = bus.r0_req | bus.r1_req;
  assign pick    = (bus.r0_req & bus.r1_req) ? ~last : bus.r1_req;
  assign start   = state == IDLE && any_req;
  assign expire  = (state == ISSUE || state == WAIT) && wd == WW'(TIMEOUT_CYCLES - 1);
  assign done_ok = state == WAIT && bus.m_done;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  // next state: a completion seen in WAIT outranks a simultaneous watchdog expiry
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = any_req ? ISSUE : IDLE;
      ISSUE:   next = expire ? ACK : bus.m_ready ? WAIT : ISSUE;
      WAIT:    next = (bus.m_done | expire) ? ACK : WAIT;
      default: next = IDLE;
    endcase
  end
  // outputs decoded from state; the ACK state is exactly the one-cycle completion pulse
  always_comb begin
    bus.m_valid     = state == ISSUE;
    bus.busy        = state != IDLE;
    bus.r0_ack      = state == ACK && !bus.grant;
    bus.r1_ack      = state == ACK && bus.grant;
    bus.timeout_err = state == ACK && to_flag;
  end
  // command latch, owner tracking, watchdog and read-data return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_addr   <= ADDRESS_BITWIDTH'(0);
      bus.m_write  <= 1'b0;
      bus.m_wdata  <= DATA_BITWIDTH'(0);
      bus.grant    <= 1'b0;
      bus.r0_rdata <= DATA_BITWIDTH'(0);
      bus.r1_rdata <= DATA_BITWIDTH'(0);
      last         <= 1'b1;
      to_flag      <= 1'b0;
      wd           <= '0;
    end else begin
      if (start) begin
        bus.grant   <= pick;
        bus.m_addr  <= pick ? bus.r1_addr : bus.r0_addr;
        bus.m_write <= pick ? bus.r1_write : bus.r0_write;
        bus.m_wdata <= pick ? bus.r1_wdata : bus.r0_wdata;
        to_flag     <= 1'b0;
        wd          <= '0;
      end
      if (state == ISSUE || state == WAIT) wd <= wd + 1'b1;
      if (done_ok || expire) begin
        last    <= bus.grant;
        to_flag <= !done_ok;
        if (!bus.grant && !(done_ok && bus.m_write)) bus.r0_rdata <= done_ok ? bus.m_rdata : DATA_BITWIDTH'(0);
        if (bus.grant && !(done_ok && bus.m_write)) bus.r1_rdata <= done_ok ? bus.m_rdata : DATA_BITWIDTH'(0);
      end
    end
  end
endmodule
